// File: rtl/dot_prod_seq_pkg.sv
// Shared types and widths for the sequential dot-product block.
// Imported by the interface, the top and the saturation stage.
package dp_pkg;

  localparam int OPW       = 8;
  localparam int ACCW      = 16;
  localparam int LENW      = 4;
  localparam int SAT_SHIFT = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/dot_prod_seq_if.sv
// Operand stream, result handshake and status of dot_prod_seq.
// master drives operands and result acceptance; slave is the block.
interface dot_prod_seq_if;
  import dp_pkg::*;

  logic                   start;
  logic [LENW-1:0]        len;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [OPW-1:0]  in_a;
  logic signed [OPW-1:0]  in_b;
  logic                   res_valid;
  logic                   res_ready;
  logic [ACCW-1:0]        res_data;
  logic [OPW-1:0]         res_sat8;
  logic                   res_of;
  logic                   res_uf;
  logic                   busy;

  modport master (
    output start, len, in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data, res_sat8,
    input  res_of, res_uf, busy
  );

  modport slave (
    input  start, len, in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data, res_sat8,
    output res_of, res_uf, busy
  );

endinterface

// File: rtl/dp_sat8.sv
// Requantizes the accumulator to 8 bits, saturating on sticky
// overflow/underflow or when the scaled value leaves int8 range.
module dp_sat8
  import dp_pkg::*;
(
  input  logic signed [ACCW-1:0] acc,
  input  logic                   of,
  input  logic                   uf,
  output logic [OPW-1:0]         sat
);

  localparam logic signed [ACCW-1:0] SMAX = 16'sd127;
  localparam logic signed [ACCW-1:0] SMIN = -16'sd128;

  logic signed [ACCW-1:0] sh;

  assign sh = acc >>> SAT_SHIFT;

  // flags take precedence: a wrapped acc no longer means anything
  always_comb begin
    if (of)
      sat = 8'h7F;
    else if (uf)
      sat = 8'h80;
    else if (sh > SMAX)
      sat = 8'h7F;
    else if (sh < SMIN)
      sat = 8'h80;
    else
      sat = sh[OPW-1:0];
  end

endmodule

// File: rtl/dot_prod_seq.sv
// Sequential signed dot product: one operand pair per handshake,
// 16-bit wrapping accumulator with sticky overflow/underflow flags.
module dot_prod_seq
  import dp_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  dot_prod_seq_if.slave  bus
);

  state_t                 state;
  state_t                 state_d;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] prod;
  logic [ACCW:0]          sum;
  logic [LENW-1:0]        count;
  logic [LENW-1:0]        len_q;
  logic                   of_q;
  logic                   uf_q;
  logic                   take;
  logic                   last;
  logic [OPW-1:0]         sat;

  assign prod = bus.in_a * bus.in_b;
  assign sum  = {acc[ACCW-1], acc} + {prod[ACCW-1], prod};
  assign take = (state == ACCUM) && bus.in_valid;
  assign last = (count == len_q - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (bus.start)
          state_d = (bus.len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (take && last)
          state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.res_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state)
      ACCUM: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
      len_q <= '0;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      acc   <= '0;
      count <= '0;
      len_q <= bus.len;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
    end else if (take) begin
      acc   <= sum[ACCW-1:0];
      count <= count + 1'b1;
      of_q  <= of_q | (sum[ACCW:ACCW-1] == 2'b01);
      uf_q  <= uf_q | (sum[ACCW:ACCW-1] == 2'b10);
    end
  end

  dp_sat8 u_sat (
    .acc (acc),
    .of  (of_q),
    .uf  (uf_q),
    .sat (sat)
  );

  assign bus.res_data = acc;
  assign bus.res_sat8 = sat;
  assign bus.res_of   = of_q;
  assign bus.res_uf   = uf_q;

endmodule

// File: tb/tb_dot_prod_seq.sv
// Bench for dot_prod_seq: integer reference model checked every cycle
// plus literal expectations on directed vectors.
module tb_dot_prod_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dot_prod_seq_if bus();

  dot_prod_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: 0 idle, 1 collecting pairs, 2 result held
  int m_st, m_len, m_cnt, m_acc;
  bit m_of, m_uf;

  function automatic int m_sat();
    int sh;
    if (m_of) return 127;
    if (m_uf) return -128;
    sh = m_acc >>> 7;
    if (sh > 127) return 127;
    if (sh < -128) return -128;
    return sh;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int s;
    if (!rst_n) begin
      m_st = 0; m_len = 0; m_cnt = 0;
      m_acc = 0; m_of = 0; m_uf = 0;
    end else if (m_st == 0) begin
      if (bus.start) begin
        m_acc = 0; m_of = 0; m_uf = 0; m_cnt = 0;
        m_len = int'(bus.len);
        m_st = (m_len == 0) ? 2 : 1;
      end
    end else if (m_st == 1) begin
      if (bus.in_valid) begin
        s = m_acc + int'(bus.in_a) * int'(bus.in_b);
        if (s > 32767) begin m_of = 1; s -= 65536; end
        if (s < -32768) begin m_uf = 1; s += 65536; end
        m_acc = s;
        m_cnt++;
        if (m_cnt == m_len) m_st = 2;
      end
    end else begin
      if (bus.res_ready) m_st = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", bus.busy, m_st != 0);
      chk("in_ready", bus.in_ready, m_st == 1);
      chk("res_valid", bus.res_valid, m_st == 2);
      if (m_st != 1) begin
        chk("res_data", bus.res_data, m_acc & 32'hFFFF);
        chk("res_sat8", bus.res_sat8, m_sat() & 32'hFF);
        chk("res_of", bus.res_of, m_of);
        chk("res_uf", bus.res_uf, m_uf);
      end
    end
  end

  logic signed [7:0] va [16];
  logic signed [7:0] vb [16];

  task automatic set_pair(input int i, input int a, input int b);
    va[i] = a[7:0];
    vb[i] = b[7:0];
  endtask

  // start a vector of n, feed k pairs (optionally with idle gaps)
  task automatic send_vec(input int n, input int k, input bit gaps);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len = n[3:0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (gaps && (i % 2 == 1)) begin
        bus.in_valid = 1'b0;
        bus.in_a = 8'h55;
        repeat (2) @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_a = va[i];
      bus.in_b = vb[i];
      for (int t = 0; t < 20 && !bus.in_ready; t++) begin
        @(posedge clk); #1;
      end
      chk("in_ready_wait", bus.in_ready, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic accept_res();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk("idle_after_accept", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 0; bus.len = 0; bus.in_valid = 0;
    bus.in_a = 0; bus.in_b = 0; bus.res_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_data", bus.res_data, 0);
    chk("rst_valid", bus.res_valid, 0);

    // first edge after release, len=0 goes straight to a zero result
    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b1;
    bus.len = 4'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("len0_valid", bus.res_valid, 1);
    chk("len0_data", bus.res_data, 0);
    chk("len0_sat", bus.res_sat8, 0);
    chk("len0_flags", {bus.res_of, bus.res_uf}, 0);
    accept_res();

    set_pair(0, 2, 3); set_pair(1, 4, -5); set_pair(2, -1, -1);
    send_vec(3, 3, 0);
    chk("v1_latency", bus.res_valid, 1);
    chk("v1_data", bus.res_data, 16'hFFF3);
    chk("v1_sat", bus.res_sat8, 8'hFF);
    chk("v1_flags", {bus.res_of, bus.res_uf}, 0);
    accept_res();

    for (int i = 0; i < 3; i++) set_pair(i, -128, 127);
    send_vec(3, 3, 0);
    chk("v3_data", bus.res_data, 16'h4180);
    chk("v3_sat", bus.res_sat8, 8'h80);
    chk("v3_flags", {bus.res_of, bus.res_uf}, 2'b01);
    accept_res();

    set_pair(0, 10, 20); set_pair(1, -30, 40);
    set_pair(2, 50, -60); set_pair(3, -70, -80);
    send_vec(4, 4, 1);
    chk("gap_data", bus.res_data, 16'h0640);
    chk("gap_sat", bus.res_sat8, 8'h0C);
    accept_res();

    set_pair(0, 100, 100); set_pair(1, 100, 100);
    send_vec(2, 2, 0);
    chk("clamp_hi_sat", bus.res_sat8, 8'h7F);
    chk("clamp_hi_of", bus.res_of, 0);
    accept_res();

    set_pair(0, -100, 100); set_pair(1, -100, 100);
    send_vec(2, 2, 0);
    chk("clamp_lo_sat", bus.res_sat8, 8'h80);
    chk("clamp_lo_uf", bus.res_uf, 0);
    accept_res();

    for (int i = 0; i < 15; i++) set_pair(i, 1, 1);
    send_vec(15, 15, 0);
    chk("len15_data", bus.res_data, 16'h000F);
    accept_res();

    // overflow, then hold the result while start is pulsed
    for (int i = 0; i < 3; i++) set_pair(i, 127, 127);
    send_vec(3, 3, 0);
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1;
      bus.len = 4'd2;
      @(posedge clk); #1;
      chk("hold_data", bus.res_data, 16'hBD03);
      chk("hold_sat", bus.res_sat8, 8'h7F);
      chk("hold_flags", {bus.res_of, bus.res_uf}, 2'b10);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.start = 1'b0;
    accept_res();
    chk("idle_hold_data", bus.res_data, 16'hBD03);
    chk("idle_valid", bus.res_valid, 0);

    // reset in the middle of a vector
    for (int i = 0; i < 5; i++) set_pair(i, i + 1, i + 1);
    send_vec(5, 2, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", bus.in_ready, 0);
    chk("mid_rst_valid", bus.res_valid, 0);
    chk("mid_rst_data", bus.res_data, 0);
    chk("mid_rst_sat", bus.res_sat8, 0);
    chk("mid_rst_flags", {bus.res_of, bus.res_uf}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_pair(0, 3, 3);
    send_vec(1, 1, 0);
    chk("post_rst_data", bus.res_data, 16'h0009);
    accept_res();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_prod_seq.md
DOT_PROD_SEQ -- requirements
Module: dot_prod_seq

Interface
REQ-001 SHALL: clk  input  1  clock; all state changes on the rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: start  input  1  begin a new dot product; sampled only in IDLE.
REQ-004 SHALL: len  input  4  number of operand pairs, unsigned 0..15; sampled with start.
REQ-005 SHALL: in_valid  input  1  operand pair present on in_a/in_b.
REQ-006 SHALL: in_ready  output  1  block accepts a pair this cycle.
REQ-007 SHALL: in_a, in_b  input  8 each  signed two's-complement operands.
REQ-008 SHALL: res_valid  output  1  result held on res_* outputs.
REQ-009 SHALL: res_ready  input  1  consumer accepts the result.
REQ-010 SHALL: res_data  output  16  signed wrapped accumulator value.
REQ-011 SHALL: res_sat8  output  8  signed saturated requantized result.
REQ-012 SHALL: res_of, res_uf  output  1 each  sticky overflow / underflow flags for the vector.
REQ-013 SHALL: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL: FSM states IDLE, ACCUM and DONE.
REQ-015 SHALL: IDLE with start=1 and len!=0 -> latch len, clear acc/count/flags, go to ACCUM.
REQ-016 SHALL: IDLE with start=1 and len=0 -> clear acc/flags, go directly to DONE (result 0, flags 0).
REQ-017 SHALL: in_ready = 1 only in ACCUM; a pair is accepted on in_valid && in_ready.
REQ-018 SHALL: per accepted pair, product = in_a*in_b (16-bit signed); acc <= acc + product, 16-bit two's-complement wrap.
REQ-019 SHALL: overflow check uses a 17-bit sign-extended sum: bits[16:15]=01 sets of, =10 sets uf; flags are sticky until the next start.
REQ-020 SHALL: when the accepted pair count equals len, go to DONE on the same edge; res_valid is high in the cycle after the last handshake.
REQ-021 SHALL: in DONE, res_valid=1 and res_* remain stable until res_valid && res_ready, then go to IDLE.
REQ-022 SHALL: res_sat8 = of ? 8'h7F : uf ? 8'h80 : clamp(acc >>> 7, -128, 127).
REQ-023 SHALL: start is ignored outside IDLE; in_valid is ignored outside ACCUM.
REQ-024 SHALL: in_valid may drop mid-vector; ACCUM waits indefinitely without altering acc.
REQ-025 SHALL: res_data/flags hold their last values in IDLE; res_valid=0 in IDLE.

Reset
REQ-026 SHALL: rst_n low at any time (including mid-ACCUM or DONE) forces state IDLE and acc, count, len latch, res_data, res_sat8, res_of, res_uf, res_valid, in_ready and busy to 0 immediately.
REQ-027 SHALL: the first start is honoured on the first rising edge after rst_n deasserts.

Structure
REQ-028 SHALL: package dp_pkg holds the state enum, OPW=8, ACCW=16, LENW=4 and SAT_SHIFT=7.
REQ-029 SHALL: sub-module dp_sat8 (combinational saturation/requantization) is instantiated once; all other logic stays in dot_prod_seq.

Verification
REQ-030 SHALL: len=3, pairs (2,3),(4,-5),(-1,-1) -> res_data=16'hFFF3, res_sat8=8'hFF, of=uf=0, res_valid one cycle after the third handshake.
REQ-031 SHALL: len=3, pairs (127,127)x3 -> res_of=1, res_uf=0, res_data=16'hBD03, res_sat8=8'h7F.
REQ-032 SHALL: len=3, pairs (-128,127)x3 -> res_uf=1, res_of=0, res_data=16'h4180, res_sat8=8'h80.
REQ-033 SHALL: res_ready held low for 5 cycles in DONE with start pulsed -> res_* stable, in_ready=0, start ignored; IDLE one cycle after res_ready=1.
REQ-034 SHALL: start with len=0 -> res_valid=1 the next cycle with res_data=0, res_sat8=0, flags 0.
REQ-035 SHALL: rst_n asserted after 2 of 5 pairs -> all outputs 0, busy=0; a new len=1 pair (3,3) then yields res_data=16'h0009.
